// File: rtl/vend_change_ctrl.sv
// Vending controller: accumulates coin credit toward PRICE, strobes a vend,
// then pays change or refunds one coin per cycle, largest denomination first.
module vend_change_ctrl #(
    parameter int PRICE   = 25,
    parameter int CW      = 11,
    parameter int TIMEOUT = 1000,
    parameter int TW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    coin,
    input  logic          cancel,
    output logic [CW-1:0] credit,
    output logic          dis,
    output logic          out_n,
    output logic          out_d,
    output logic          out_q,
    output logic          coin_rej,
    output logic          busy
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);
    localparam logic [CW-1:0] NICKEL   = CW'(5);
    localparam logic [CW-1:0] DIME     = CW'(10);
    localparam logic [CW-1:0] QUARTER  = CW'(25);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          coin_rej_q, coin_rej_d;

    logic          coin_legal;
    logic [CW-1:0] coin_val;
    logic [CW-1:0] change_val;

    always_comb begin
        coin_legal = 1'b1;
        coin_val   = '0;
        case (coin)
            3'b100:  coin_val = NICKEL;
            3'b010:  coin_val = DIME;
            3'b001:  coin_val = QUARTER;
            default: coin_legal = 1'b0;
        endcase
    end

    always_comb begin
        if (credit_q >= QUARTER) begin
            change_val = QUARTER;
        end else if (credit_q >= DIME) begin
            change_val = DIME;
        end else begin
            change_val = NICKEL;
        end
    end

    // Refund request beats a simultaneous coin; an accepted coin beats the idle timeout.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        tmo_d      = '0;
        coin_rej_d = 1'b0;
        case (state_q)
            COLLECT: begin
                coin_rej_d = (coin != 3'b000) && (cancel || !coin_legal);
                if (cancel && (credit_q != '0)) begin
                    state_d = CHANGE;
                end else if (!cancel && coin_legal) begin
                    credit_d = credit_q + coin_val;
                    if (credit_d >= PRICE_C) begin
                        state_d = VEND;
                    end
                end else if ((credit_q != '0) && (tmo_q == TMO_LAST)) begin
                    state_d = CHANGE;
                end else if (credit_q != '0) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            VEND: begin
                coin_rej_d = (coin != 3'b000);
                credit_d   = credit_q - PRICE_C;
                state_d    = (credit_d != '0) ? CHANGE : COLLECT;
            end
            CHANGE: begin
                coin_rej_d = (coin != 3'b000);
                credit_d   = credit_q - change_val;
                if (credit_d == '0) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d  = COLLECT;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            credit_q   <= '0;
            tmo_q      <= '0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            tmo_q      <= tmo_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    assign credit   = credit_q;
    assign coin_rej = coin_rej_q;
    assign dis      = (state_q == VEND);
    assign busy     = (state_q != COLLECT);
    assign out_q    = (state_q == CHANGE) && (credit_q >= QUARTER);
    assign out_d    = (state_q == CHANGE) && (credit_q < QUARTER) && (credit_q >= DIME);
    assign out_n    = (state_q == CHANGE) && (credit_q < DIME);

endmodule
